// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and defaults for the MEM-stage SRAM controller
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    localparam int DEF_ADDR_BASE = 1024;
    localparam int DEF_SRAM_DW   = 16;
    localparam int DEF_SRAM_AW   = 18;

    // Number of SRAM beats needed to move one CPU word
    function automatic int calc_beats(input int data_w, input int sram_dw);
        return data_w / sram_dw;
    endfunction

    // Counter width for a beat index, never narrower than one bit
    function automatic int beat_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/mem_addr_map.sv
// rtl/mem_addr_map.sv - CPU byte address to SRAM word base and window check
module mem_addr_map
    import mem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'(DEF_ADDR_BASE),
    parameter int          DATA_W    = 32,
    parameter int          SRAM_DW   = DEF_SRAM_DW,
    parameter int          SRAM_AW   = DEF_SRAM_AW
) (
    input  logic [31:0]        address,
    output logic [SRAM_AW-1:0] word_base,
    output logic               in_range
);

    localparam int BEATS      = calc_beats(DATA_W, SRAM_DW);
    localparam int BYTE_SHIFT = $clog2(DATA_W / 8);
    // Wide enough that word*BEATS + BEATS-1 never wraps for any 32-bit offset
    localparam int EXT_W      = 40;

    logic [31:0]      offs;
    logic [EXT_W-1:0] first_beat;
    logic [EXT_W-1:0] last_beat;

    // Offset into the window, drop byte-lane bits, scale to SRAM beats
    always_comb begin
        offs       = address - ADDR_BASE;
        first_beat = EXT_W'(offs >> BYTE_SHIFT) * EXT_W'(BEATS);
        last_beat  = first_beat + EXT_W'(BEATS - 1);
        in_range   = (address >= ADDR_BASE) && (last_beat < (EXT_W'(1) << SRAM_AW));
        word_base  = first_beat[SRAM_AW-1:0];
    end

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - MEM-stage controller splitting CPU accesses into SRAM beats
module mem_stage_sram_ctrl
    import mem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'(DEF_ADDR_BASE),
    parameter int          DATA_W      = 32,
    parameter int          SRAM_DW     = DEF_SRAM_DW,
    parameter int          SRAM_AW     = DEF_SRAM_AW,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [31:0]        address,
    input  logic [DATA_W-1:0]  write_data,
    output logic [DATA_W-1:0]  read_data,
    output logic               ready,
    output logic               freeze,
    output logic               addr_err,
    inout  wire  [SRAM_DW-1:0] sram_dq,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_ub_n,
    output logic               sram_lb_n,
    output logic               sram_we_n,
    output logic               sram_ce_n,
    output logic               sram_oe_n
);

    localparam int                BEATS     = calc_beats(DATA_W, SRAM_DW);
    localparam int                BEAT_W    = beat_width(BEATS);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
    localparam logic [3:0]        WAIT_LAST = 4'(WAIT_CYCLES);

    mem_state_t          state;
    logic                op_write_q;
    logic [SRAM_AW-1:0]  base_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [3:0]          cnt_q;

    logic                req;
    logic                map_in_range;
    logic [SRAM_AW-1:0]  map_base;
    logic                beat_done;
    logic                in_access;
    logic                dq_drive;
    logic [SRAM_DW-1:0]  wr_slice;

    mem_addr_map #(
        .ADDR_BASE (ADDR_BASE),
        .DATA_W    (DATA_W),
        .SRAM_DW   (SRAM_DW),
        .SRAM_AW   (SRAM_AW)
    ) u_addr_map (
        .address   (address),
        .word_base (map_base),
        .in_range  (map_in_range)
    );

    // Request decode: freeze rises in the accepting cycle, rejects pulse addr_err
    always_comb begin
        req       = mem_read | mem_write;
        beat_done = (cnt_q == WAIT_LAST);
        in_access = (state == ACCESS);
        freeze    = rst && (in_access || ((state == IDLE) && req && map_in_range));
        addr_err  = rst && (state == IDLE) && req && !map_in_range;
    end

    // Access sequencer: latch operands, step beats with wait states, report completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            read_data  <= '0;
            ready      <= 1'b0;
            op_write_q <= 1'b0;
            base_q     <= '0;
            wdata_q    <= '0;
            beat_q     <= '0;
            cnt_q      <= '0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (req && map_in_range) begin
                        // A simultaneous read and write is treated as a write
                        op_write_q <= mem_write;
                        base_q     <= map_base;
                        wdata_q    <= write_data;
                        beat_q     <= '0;
                        cnt_q      <= '0;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (beat_done) begin
                        if (!op_write_q) begin
                            read_data[int'(beat_q)*SRAM_DW +: SRAM_DW] <= sram_dq;
                        end
                        cnt_q <= '0;
                        if (beat_q == BEAT_LAST) begin
                            state <= DONE;
                            ready <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // SRAM bus decode from registered state; reset forces every strobe inactive at once
    always_comb begin
        sram_ce_n = !in_access;
        sram_ub_n = !in_access;
        sram_lb_n = !in_access;
        sram_we_n = !(in_access && op_write_q);
        sram_oe_n = !(in_access && !op_write_q);
        sram_addr = in_access ? (base_q + SRAM_AW'(beat_q)) : '0;
        dq_drive  = in_access && op_write_q;
        wr_slice  = wdata_q[int'(beat_q)*SRAM_DW +: SRAM_DW];
    end

    // Data bus is driven only while writing, so it never overlaps output enable
    assign sram_dq = dq_drive ? wr_slice : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb/tb_mem_stage_sram_ctrl.sv - self-checking bench for mem_stage_sram_ctrl
module tb_mem_stage_sram_ctrl;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [63:0] wd;
        logic        exp_err;
        logic [17:0] exp_b0;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [63:0] write_data;

    logic [31:0] a_read_data;
    logic        a_ready, a_freeze, a_addr_err;
    wire  [15:0] a_dq;
    logic [17:0] a_addr;
    logic        a_ub_n, a_lb_n, a_we_n, a_ce_n, a_oe_n;

    logic [63:0] b_read_data;
    logic        b_ready, b_freeze, b_addr_err;
    wire  [15:0] b_dq;
    logic [17:0] b_addr;
    logic        b_ub_n, b_lb_n, b_we_n, b_ce_n, b_oe_n;

    logic [15:0] mem_a [64];
    logic [15:0] mem_b [64];
    logic [15:0] shadow_a [int];
    logic [31:0] exp_q [$];
    logic [31:0] last_rd;
    logic [17:0] log_a [$];
    logic [17:0] log_b [$];

    int n_checks = 0;
    int n_fail   = 0;
    int fz_a, rdy_a, err_a, rdy_cyc_a;
    int fz_b, rdy_b, err_b, rdy_cyc_b;
    logic [31:0] rdata_a;
    logic [63:0] rdata_b;

    vec_t vecs [13];

    always #5 clk = ~clk;

    mem_stage_sram_ctrl u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .address    (address),
        .write_data (write_data[31:0]),
        .read_data  (a_read_data),
        .ready      (a_ready),
        .freeze     (a_freeze),
        .addr_err   (a_addr_err),
        .sram_dq    (a_dq),
        .sram_addr  (a_addr),
        .sram_ub_n  (a_ub_n),
        .sram_lb_n  (a_lb_n),
        .sram_we_n  (a_we_n),
        .sram_ce_n  (a_ce_n),
        .sram_oe_n  (a_oe_n)
    );

    mem_stage_sram_ctrl #(.DATA_W(64), .WAIT_CYCLES(0)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .address    (address),
        .write_data (write_data),
        .read_data  (b_read_data),
        .ready      (b_ready),
        .freeze     (b_freeze),
        .addr_err   (b_addr_err),
        .sram_dq    (b_dq),
        .sram_addr  (b_addr),
        .sram_ub_n  (b_ub_n),
        .sram_lb_n  (b_lb_n),
        .sram_we_n  (b_we_n),
        .sram_ce_n  (b_ce_n),
        .sram_oe_n  (b_oe_n)
    );

    assign a_dq = (!a_ce_n && !a_oe_n) ? mem_a[a_addr[5:0]] : 16'hzzzz;
    assign b_dq = (!b_ce_n && !b_oe_n) ? mem_b[b_addr[5:0]] : 16'hzzzz;

    // SRAM models and bus monitors, sampled mid-cycle
    always @(negedge clk) begin
        if (!a_ce_n) log_a.push_back(a_addr);
        if (!b_ce_n) log_b.push_back(b_addr);
        if (!a_ce_n && !a_we_n) mem_a[a_addr[5:0]] <= a_dq;
        if (!b_ce_n && !b_we_n) mem_b[b_addr[5:0]] <= b_dq;
        if ((!a_oe_n && !a_we_n) || (!b_oe_n && !b_we_n)) begin
            n_fail++;
            $display("FAIL bus_contention: oe_n and we_n both low at %0t", $time);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One request cycle followed by a fixed observation window; starts and ends on a falling edge
    task automatic run(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [63:0] wd, input int chg_cycle, input logic [31:0] chg_addr);
        log_a.delete();
        log_b.delete();
        fz_a = 0; rdy_a = 0; err_a = 0; rdy_cyc_a = -1;
        fz_b = 0; rdy_b = 0; err_b = 0; rdy_cyc_b = -1;
        for (int c = 0; c < 16; c++) begin
            if (c == 0) begin
                mem_read = rd; mem_write = wr; address = addr; write_data = wd;
            end else begin
                mem_read = 1'b0; mem_write = 1'b0;
                if (c == chg_cycle) address = chg_addr;
            end
            #1;
            if (a_freeze)   fz_a++;
            if (a_addr_err) err_a++;
            if (a_ready) begin rdy_a++; rdy_cyc_a = c; rdata_a = a_read_data; end
            if (b_freeze)   fz_b++;
            if (b_addr_err) err_b++;
            if (b_ready) begin rdy_b++; rdy_cyc_b = c; rdata_b = b_read_data; end
            @(negedge clk);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 32'd1024,   64'hDEADBEEF, 1'b0, 18'd0};
        vecs[1]  = '{1'b1, 1'b0, 32'd1024,   64'h0,        1'b0, 18'd0};
        vecs[2]  = '{1'b0, 1'b1, 32'd1032,   64'hCAFEF00D, 1'b0, 18'd4};
        vecs[3]  = '{1'b0, 1'b1, 32'd1028,   64'h11112222, 1'b0, 18'd2};
        vecs[4]  = '{1'b1, 1'b0, 32'd1030,   64'h0,        1'b0, 18'd2};
        vecs[5]  = '{1'b1, 1'b0, 32'd1032,   64'h0,        1'b0, 18'd4};
        vecs[6]  = '{1'b1, 1'b0, 32'd1020,   64'h0,        1'b1, 18'd0};
        vecs[7]  = '{1'b0, 1'b1, 32'd525312, 64'h55AA55AA, 1'b1, 18'd0};
        vecs[8]  = '{1'b0, 1'b1, 32'd525308, 64'h0BADC0DE, 1'b0, 18'd262142};
        vecs[9]  = '{1'b1, 1'b0, 32'd525308, 64'h0,        1'b0, 18'd262142};
        vecs[10] = '{1'b1, 1'b1, 32'd1036,   64'h12345678, 1'b0, 18'd6};
        vecs[11] = '{1'b1, 1'b0, 32'd1036,   64'h0,        1'b0, 18'd6};
        vecs[12] = '{1'b1, 1'b0, 32'd0,      64'h0,        1'b1, 18'd0};

        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; address = '0; write_data = '0;
        last_rd = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst ready",     64'(a_ready),     64'd0);
        check("rst freeze",    64'(a_freeze),    64'd0);
        check("rst addr_err",  64'(a_addr_err),  64'd0);
        check("rst read_data", 64'(a_read_data), 64'd0);
        check("rst ctrl_n",    64'({a_ce_n, a_we_n, a_oe_n, a_ub_n, a_lb_n}), 64'h1F);
        check("rst sram_addr", 64'(a_addr),      64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            vec_t v;
            int   b0;
            v  = vecs[i];
            b0 = int'(v.exp_b0);
            if (v.rd && !v.wr && !v.exp_err) exp_q.push_back({shadow_a[b0+1], shadow_a[b0]});
            run(v.rd, v.wr, v.addr, v.wd, -1, 32'd0);
            check($sformatf("v%0d addr_err", i), 64'(err_a), v.exp_err ? 64'd1 : 64'd0);
            check($sformatf("v%0d freeze_cycles", i), 64'(fz_a), v.exp_err ? 64'd0 : 64'd5);
            check($sformatf("v%0d ready_pulses", i), 64'(rdy_a), v.exp_err ? 64'd0 : 64'd1);
            check($sformatf("v%0d beat_cycles", i), 64'(log_a.size()), v.exp_err ? 64'd0 : 64'd4);
            foreach (log_a[j]) check($sformatf("v%0d beat_addr%0d", i, j), 64'(log_a[j]), 64'(b0 + j/2));
            if (!v.exp_err) check($sformatf("v%0d ready_cycle", i), 64'(rdy_cyc_a), 64'd5);
            if (v.wr && !v.exp_err) begin
                shadow_a[b0]   = v.wd[15:0];
                shadow_a[b0+1] = v.wd[31:16];
                check($sformatf("v%0d sram_lo", i), 64'(mem_a[v.exp_b0[5:0]]),        64'(v.wd[15:0]));
                check($sformatf("v%0d sram_hi", i), 64'(mem_a[v.exp_b0[5:0] + 6'd1]), 64'(v.wd[31:16]));
            end
            if (v.rd && !v.wr && rdy_a == 1 && exp_q.size() > 0) begin
                last_rd = exp_q.pop_front();
                check($sformatf("v%0d read_data", i), 64'(rdata_a), 64'(last_rd));
            end else begin
                check($sformatf("v%0d read_data_held", i), 64'(a_read_data), 64'(last_rd));
            end
        end

        // 64-bit, zero-wait instance: consecutive beats, address changed mid-access
        run(1'b0, 1'b1, 32'd1040, 64'h0123456789ABCDEF, 2, 32'd1024);
        check("b write freeze", 64'(fz_b), 64'd5);
        check("b write ready_cycle", 64'(rdy_cyc_b), 64'd5);
        check("b write beats", 64'(log_b.size()), 64'd4);
        foreach (log_b[j]) check($sformatf("b beat_addr%0d", j), 64'(log_b[j]), 64'(8 + j));
        check("b sram w8",  64'(mem_b[8]),  64'hCDEF);
        check("b sram w9",  64'(mem_b[9]),  64'h89AB);
        check("b sram w10", 64'(mem_b[10]), 64'h4567);
        check("b sram w11", 64'(mem_b[11]), 64'h0123);
        foreach (log_a[j]) check($sformatf("a latched beat%0d", j), 64'(log_a[j]), 64'(8 + j/2));
        shadow_a[8] = 16'hCDEF;
        shadow_a[9] = 16'h89AB;

        exp_q.push_back({shadow_a[9], shadow_a[8]});
        run(1'b1, 1'b0, 32'd1040, 64'h0, 3, 32'd1024);
        check("b read freeze", 64'(fz_b), 64'd5);
        check("b read_data", rdata_b, 64'h0123456789ABCDEF);
        if (rdy_a == 1 && exp_q.size() > 0) begin
            last_rd = exp_q.pop_front();
            check("a read 1040", 64'(rdata_a), 64'(last_rd));
        end

        // Reset during beat 0 of a write
        mem_write = 1'b1; address = 32'd1024; write_data = 64'hAAAA5555;
        @(negedge clk);
        mem_write = 1'b0;
        #1;
        check("mid we_n active", 64'(a_we_n), 64'd0);
        rst = 1'b0;
        #1;
        check("mid rst ctrl_n",    64'({a_ce_n, a_we_n, a_oe_n, a_ub_n, a_lb_n}), 64'h1F);
        check("mid rst sram_addr", 64'(a_addr),      64'd0);
        check("mid rst freeze",    64'(a_freeze),    64'd0);
        check("mid rst read_data", 64'(a_read_data), 64'd0);
        check("mid rst b ctrl_n",  64'({b_ce_n, b_we_n, b_oe_n}), 64'h7);
        check("mid rst b read",    b_read_data,      64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("post rst freeze", 64'(a_freeze), 64'd0);
        check("post rst ready",  64'(a_ready),  64'd0);
        check("post rst ce_n",   64'(a_ce_n),   64'd1);
        @(negedge clk);
        last_rd = '0;

        exp_q.push_back({shadow_a[5], shadow_a[4]});
        run(1'b1, 1'b0, 32'd1032, 64'h0, -1, 32'd0);
        check("post rst read freeze", 64'(fz_a), 64'd5);
        if (rdy_a == 1 && exp_q.size() > 0) begin
            last_rd = exp_q.pop_front();
            check("post rst read_data", 64'(rdata_a), 64'(last_rd));
        end
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
